// File: rtl/run_monitor.sv
// run_monitor: run/completion monitor for the N-core main-memory system.
// Watches each core's PC for a halt address and records the cycle at which
// each core halted. Once every core has halted (or the run times out), it
// waits a fixed pipeline-drain interval and then samples each core's result
// register. A zero result means pass; any other value means fail. The
// done/pass status is then held until the next start.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   start        single-cycle run request (accepted in IDLE/DONE only)
//   pc           core i PC at [i*ADDRESS_BITS +: ADDRESS_BITS]
//   result_reg   core i result register at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy         high while running or draining
//   done         high once results have been sampled
//   pass         all cores halted with zero result and no timeout (valid with done)
//   timeout      run hit MAX_CYCLES before every core halted
//   halted       per-core halt-seen flags
//   fail_mask    per-core fail flags (valid with done)
//   core_cycles  per-core RUN cycle count at halt, [i*CYCLE_BITS +: CYCLE_BITS]
module run_monitor #(
  parameter int unsigned NUM_CORES    = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned CYCLE_BITS   = 32,
  parameter logic [ADDRESS_BITS-1:0] HALT_PC_0 = ADDRESS_BITS'(32'h000000b0),
  parameter logic [ADDRESS_BITS-1:0] HALT_PC_1 = ADDRESS_BITS'(32'h000000b4),
  parameter int unsigned DRAIN_CYCLES = 50,
  parameter int unsigned MAX_CYCLES   = 100000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0]  pc,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]    result_reg,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [NUM_CORES-1:0]               halted,
  output logic [NUM_CORES-1:0]               fail_mask,
  output logic [NUM_CORES*CYCLE_BITS-1:0]    core_cycles
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam longint unsigned MAX_CYCLES_L = 64'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CYCLE_BITS-1:0]  cycle_cnt;
  logic [DRAIN_W-1:0]     drain_cnt;

  logic [CYCLE_BITS-1:0]  cycle_inc;
  logic [NUM_CORES-1:0]   match;
  logic [NUM_CORES-1:0]   halted_nxt;
  logic [NUM_CORES-1:0]   result_zero;
  logic                   all_halted;
  logic                   tmo_hit;

  // Saturating RUN cycle count as it will read after this edge.
  assign cycle_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CYCLE_BITS'(1);

  // Per-core halt detection; a core that already halted never re-matches.
  always_comb begin
    match       = '0;
    result_zero = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      match[i] = (state == S_RUN) && !halted[i] &&
                 ((pc[i*ADDRESS_BITS +: ADDRESS_BITS] == HALT_PC_0) ||
                  (pc[i*ADDRESS_BITS +: ADDRESS_BITS] == HALT_PC_1));
      result_zero[i] = (result_reg[i*DATA_WIDTH +: DATA_WIDTH] == '0);
    end
  end

  assign halted_nxt = halted | match;
  assign all_halted = &halted_nxt;
  // Compared at 64 bits so a MAX_CYCLES wider than the counter never fires.
  assign tmo_hit    = (MAX_CYCLES != 0) && (64'(cycle_inc) == MAX_CYCLES_L);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a halt in the timeout cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (all_halted || tmo_hit) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      drain_cnt   <= '0;
      halted      <= '0;
      core_cycles <= '0;
      fail_mask   <= '0;
      timeout     <= 1'b0;
      pass        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cycle_cnt   <= '0;
            halted      <= '0;
            core_cycles <= '0;
            fail_mask   <= '0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
          end
        end
        S_RUN: begin
          cycle_cnt <= cycle_inc;
          halted    <= halted_nxt;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (match[i]) core_cycles[i*CYCLE_BITS +: CYCLE_BITS] <= cycle_inc;
          end
          if (all_halted) begin
            drain_cnt <= DRAIN_LOAD;
          end else if (tmo_hit) begin
            drain_cnt <= DRAIN_LOAD;
            timeout   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            fail_mask <= ~result_zero | ~halted;
            pass      <= (&result_zero) && (&halted) && !timeout;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: pass, fail, timeout, simultaneous halts,
// reset mid-drain and restart behaviour, with hand-computed expectations.
module tb_run_monitor;

  localparam int unsigned NC = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned CB = 32;
  localparam logic [31:0] NOHALT = 32'h0000_0100;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [NC*AW-1:0]    pc;
  logic [NC*DW-1:0]    result_reg;
  logic                busy;
  logic                done;
  logic                pass;
  logic                timeout;
  logic [NC-1:0]       halted;
  logic [NC-1:0]       fail_mask;
  logic [NC*CB-1:0]    core_cycles;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clock = ~clock;

  run_monitor #(
    .NUM_CORES(NC), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .CYCLE_BITS(CB),
    .HALT_PC_0(32'h000000b0), .HALT_PC_1(32'h000000b4),
    .DRAIN_CYCLES(50), .MAX_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .pc(pc),
    .result_reg(result_reg), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .halted(halted), .fail_mask(fail_mask),
    .core_cycles(core_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Start a run; core i sits at its halt address from RUN cycle ci on
  // (0 = never halts). start is re-asserted in RUN cycle start_at, and the
  // run is abandoned after stop_at cycles when stop_at != 0.
  // cycles returns the number of cycles spent busy before done was seen.
  task automatic do_run(input int c0, input int c1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input int start_at, input int stop_at,
                        output int cycles);
    pc = {NOHALT, NOHALT};
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    check("start_pass_clr", 64'(pass), 64'd0);
    check("start_fmask_clr", 64'(fail_mask), 64'd0);
    check("start_cc_clr", 64'(core_cycles), 64'd0);
    cycles = 0;
    while (!done && cycles < 2000 && !(stop_at != 0 && cycles >= stop_at)) begin
      cycles++;
      pc[0 +: AW]  = (c0 != 0 && cycles >= c0) ? a0 : NOHALT;
      pc[AW +: AW] = (c1 != 0 && cycles >= c1) ? a1 : NOHALT;
      start = (cycles == start_at);
      tick;
    end
    start = 1'b0;
    if (stop_at == 0) check("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    pc = {NOHALT, NOHALT};
    result_reg = '0;
    repeat (5) tick;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_status", 64'({pass, timeout, halted, fail_mask}), 64'd0);
    check("rst_cc", 64'(core_cycles), 64'd0);
    reset = 1'b1;
    tick;

    // 1: basic pass
    do_run(20, 35, 32'hb0, 32'hb4, 0, 0, n);
    check("t1_busy_len", 64'(n), 64'd85);
    check("t1_halted", 64'(halted), 64'b11);
    check("t1_cc", 64'(core_cycles), {32'd35, 32'd20});
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_fmask", 64'(fail_mask), 64'd0);
    check("t1_timeout", 64'(timeout), 64'd0);
    check("t1_busy_low", 64'(busy), 64'd0);

    // 2: core1 reports failure; later result changes are not sampled
    result_reg = {32'h0000_0003, 32'h0};
    do_run(20, 35, 32'hb0, 32'hb4, 0, 0, n);
    check("t2_pass", 64'(pass), 64'd0);
    check("t2_fmask", 64'(fail_mask), 64'b10);
    result_reg = {32'h0, 32'h0000_0005};
    repeat (3) tick;
    check("t2_fmask_hold", 64'(fail_mask), 64'b10);
    check("t2_pass_hold", 64'(pass), 64'd0);
    check("t2_done_hold", 64'(done), 64'd1);
    result_reg = '0;

    // 3: timeout with only core0 halting
    do_run(10, 0, 32'hb0, 32'hb4, 0, 0, n);
    check("t3_busy_len", 64'(n), 64'd150);
    check("t3_timeout", 64'(timeout), 64'd1);
    check("t3_halted", 64'(halted), 64'b01);
    check("t3_cc", 64'(core_cycles), {32'd0, 32'd10});
    check("t3_fmask", 64'(fail_mask), 64'b10);
    check("t3_pass", 64'(pass), 64'd0);

    // 4a: both cores halt in the first RUN cycle at the same address
    do_run(1, 1, 32'hb0, 32'hb0, 0, 0, n);
    check("t4a_busy_len", 64'(n), 64'd51);
    check("t4a_cc", 64'(core_cycles), {32'd1, 32'd1});
    check("t4a_pass", 64'(pass), 64'd1);

    // 4b: last core halts in the timeout cycle; core0 keeps re-hitting 0xb0
    do_run(10, 100, 32'hb0, 32'hb4, 0, 0, n);
    check("t4b_busy_len", 64'(n), 64'd150);
    check("t4b_timeout", 64'(timeout), 64'd0);
    check("t4b_cc", 64'(core_cycles), {32'd100, 32'd10});
    check("t4b_pass", 64'(pass), 64'd1);

    // 5: reset 10 cycles into DRAIN, then a clean run
    do_run(20, 35, 32'hb0, 32'hb4, 0, 45, n);
    check("t5_busy_pre", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_status", 64'({pass, timeout, halted}), 64'd0);
    check("t5_cc", 64'(core_cycles), 64'd0);
    repeat (2) tick;
    reset = 1'b1;
    tick;
    do_run(20, 35, 32'hb0, 32'hb4, 0, 0, n);
    check("t5_rerun_len", 64'(n), 64'd85);
    check("t5_rerun_cc", 64'(core_cycles), {32'd35, 32'd20});
    check("t5_rerun_pass", 64'(pass), 64'd1);

    // 6: start during RUN is ignored; start in DONE restarts counting at 1
    do_run(20, 35, 32'hb0, 32'hb4, 25, 0, n);
    check("t6_busy_len", 64'(n), 64'd85);
    check("t6_cc", 64'(core_cycles), {32'd35, 32'd20});
    do_run(3, 4, 32'hb4, 32'hb0, 0, 0, n);
    check("t6_rerun_len", 64'(n), 64'd54);
    check("t6_rerun_cc", 64'(core_cycles), {32'd4, 32'd3});
    check("t6_rerun_pass", 64'(pass), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
